// File: rtl/tmds_encoder.sv
// tmds_encoder: three-lane DVI TMDS encoder with a 2-cycle pipeline and bit-sliced symbol outputs.
module tmds_encoder #(
    parameter int CNT_W = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       de_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic [2:0] tmds_d0_o,
    output logic [2:0] tmds_d1_o,
    output logic [2:0] tmds_d2_o,
    output logic [2:0] tmds_d3_o,
    output logic [2:0] tmds_d4_o,
    output logic [2:0] tmds_d5_o,
    output logic [2:0] tmds_d6_o,
    output logic [2:0] tmds_d7_o,
    output logic [2:0] tmds_d8_o,
    output logic [2:0] tmds_d9_o
);
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

    function automatic logic [8:0] qm_of(input logic [7:0] d);
        logic [8:0] qm;
        logic       x;
        int         n1;
        n1    = $countones(d);
        x     = n1 > 4 || (n1 == 4 && !d[0]);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : qm[i-1] ^ d[i];
        qm[8] = ~x;
        return qm;
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        return c == 2'b00 ? 10'b1101010100 :
               c == 2'b01 ? 10'b0010101011 :
               c == 2'b10 ? 10'b0101010100 : 10'b1010101011;
    endfunction

    logic [23:0] pix;
    logic        de_q;
    logic [1:0]  ctl_q;
    logic [9:0]  sym [3];

    assign pix = {red_i, green_i, blue_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            de_q  <= 1'b0;
            ctl_q <= 2'b00;
        end else begin
            de_q  <= de_i;
            ctl_q <= {vsync_i, hsync_i};
        end
    end

    for (genvar l = 0; l < 3; l++) begin : g_lane
        logic        [8:0]       qm_q;
        logic        [9:0]       sym_q, sym_d;
        logic signed [CNT_W-1:0] cnt_q, cnt_d, diff;
        logic        [3:0]       n1q;
        logic        [1:0]       ctl;
        logic                    bal, inv;

        // only the blue lane carries HSYNC/VSYNC
        assign ctl = l == 0 ? ctl_q : 2'b00;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                qm_q  <= '0;
                sym_q <= '0;
                cnt_q <= '0;
            end else begin
                qm_q  <= qm_of(pix[8*l +: 8]);
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
        end

        always_comb begin
            n1q   = 4'($countones(qm_q[7:0]));
            diff  = $signed(CNT_W'({n1q, 1'b0})) - EIGHT;
            bal   = cnt_q == 0 || diff == 0;
            inv   = (cnt_q > 0 && diff > 0) || (cnt_q < 0 && diff < 0);
            sym_d = !de_q ? ctl_sym(ctl) :
                    bal   ? {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]} :
                    inv   ? {1'b1, qm_q[8], ~qm_q[7:0]} : {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = !de_q ? '0 :
                    bal   ? (qm_q[8] ? cnt_q + diff : cnt_q - diff) :
                    inv   ? cnt_q + (qm_q[8] ? TWO : '0) - diff :
                            cnt_q - (qm_q[8] ? '0 : TWO) + diff;
        end

        assign sym[l] = sym_q;
    end

    assign tmds_d0_o = {sym[2][0], sym[1][0], sym[0][0]};
    assign tmds_d1_o = {sym[2][1], sym[1][1], sym[0][1]};
    assign tmds_d2_o = {sym[2][2], sym[1][2], sym[0][2]};
    assign tmds_d3_o = {sym[2][3], sym[1][3], sym[0][3]};
    assign tmds_d4_o = {sym[2][4], sym[1][4], sym[0][4]};
    assign tmds_d5_o = {sym[2][5], sym[1][5], sym[0][5]};
    assign tmds_d6_o = {sym[2][6], sym[1][6], sym[0][6]};
    assign tmds_d7_o = {sym[2][7], sym[1][7], sym[0][7]};
    assign tmds_d8_o = {sym[2][8], sym[1][8], sym[0][8]};
    assign tmds_d9_o = {sym[2][9], sym[1][9], sym[0][9]};
endmodule
